// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the decode-to-writeback control pipeline:
// control word field positions, stage indices and per-stage keep masks.
package ctrl_pipe_pkg;

  localparam int CW_DEFAULT     = 16;
  localparam int NSTAGE_DEFAULT = 4;

  localparam int MEMTOREG   = 0;
  localparam int MEMWRITE   = 1;
  localparam int ALUSRC     = 2;
  localparam int REGDST     = 3;
  localparam int REGWRITE   = 4;
  localparam int SIGN_EXT   = 5;
  localparam int WRITE_HILO = 6;
  localparam int MEMEN      = 7;
  localparam int ALUOP_LSB  = 8;
  localparam int ALUOP_MSB  = 15;

  localparam int ST_E = 0;
  localparam int ST_M = 1;
  localparam int ST_W = 2;

  typedef struct packed {
    logic [7:0] aluop;
    logic       memen;
    logic       writeHilo;
    logic       signExt;
    logic       regWrite;
    logic       regDst;
    logic       aluSrc;
    logic       memWrite;
    logic       memToReg;
  } ctrl_word_t;

  function automatic logic [CW_DEFAULT-1:0] fieldBit(input int pos);
    return CW_DEFAULT'(1) << pos;
  endfunction

  // Execute needs everything; memory and writeback keep only what they consume.
  localparam logic [CW_DEFAULT-1:0] KEEP_E = '1;
  localparam logic [CW_DEFAULT-1:0] KEEP_M =
    fieldBit(MEMTOREG) | fieldBit(MEMWRITE) | fieldBit(REGWRITE) |
    fieldBit(WRITE_HILO) | fieldBit(MEMEN);
  localparam logic [CW_DEFAULT-1:0] KEEP_W =
    fieldBit(MEMTOREG) | fieldBit(REGWRITE) | fieldBit(WRITE_HILO);

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decoder-side inputs and per-stage outputs of the control pipeline.
interface ctrl_pipe_if
  import ctrl_pipe_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEFAULT,
  parameter int CW     = CW_DEFAULT
);
  logic [CW-1:0]                  ctrl_d;
  logic                           valid_d;
  logic                           stall_d;
  logic [NSTAGE-1:0]              stall;
  logic [NSTAGE-1:0]              flush;
  logic [NSTAGE*CW-1:0]           ctrl_q;
  logic [NSTAGE-1:0]              valid_q;
  logic [$clog2(NSTAGE+1)-1:0]    occ_cnt;
  logic                           stall_err;

  modport master (
    output ctrl_d, valid_d, stall_d, stall, flush,
    input  ctrl_q, valid_q, occ_cnt, stall_err
  );

  modport slave (
    input  ctrl_d, valid_d, stall_d, stall, flush,
    output ctrl_q, valid_q, occ_cnt, stall_err
  );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// One control pipeline register: flush, then stall, then bubble, then advance.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int            CW   = CW_DEFAULT,
  parameter logic [CW-1:0] MASK = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] upCtrl,
  input  logic          upValid,
  input  logic          upStall,
  input  logic          stall,
  input  logic          flush,
  output logic [CW-1:0] ctrlQ,
  output logic          validQ
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ <= 1'b0;
      ctrlQ  <= '0;
    end else if (flush) begin
      validQ <= 1'b0;
      ctrlQ  <= '0;
    end else if (!stall) begin
      if (upStall) begin
        validQ <= 1'b0;
        ctrlQ  <= '0;
      end else begin
        // Empty slots always carry a zero word so consumers need not gate on valid.
        validQ <= upValid;
        ctrlQ  <= upValid ? (upCtrl & MASK) : '0;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline from decode to writeback: NSTAGE stage registers,
// a sticky detector for stalls that would clobber live data, and occupancy.
module ctrl_pipe_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int                   NSTAGE    = NSTAGE_DEFAULT,
  parameter int                   CW        = CW_DEFAULT,
  parameter logic [NSTAGE*CW-1:0] KEEP_MASK = {NSTAGE*CW{1'b1}}
) (
  input  logic      clk,
  input  logic      rst,
  ctrl_pipe_if.slave bus
);

  localparam int OCW = $clog2(NSTAGE + 1);

  logic [NSTAGE*CW-1:0] ctrlQ;
  logic [NSTAGE-1:0]    validQ;
  logic [NSTAGE*CW-1:0] upCtrl;
  logic [NSTAGE-1:0]    upValid;
  logic [NSTAGE-1:0]    upStall;
  logic                 errSet;
  logic                 stallErr;
  logic [OCW-1:0]       occCnt;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign upCtrl[0 +: CW] = bus.ctrl_d;
      assign upValid[0]      = bus.valid_d;
      assign upStall[0]      = bus.stall_d;
    end else begin : g_body
      assign upCtrl[k*CW +: CW] = ctrlQ[(k-1)*CW +: CW];
      assign upValid[k]         = validQ[k-1];
      assign upStall[k]         = bus.stall[k-1];
    end

    ctrl_pipe_stage #(
      .CW   (CW),
      .MASK (KEEP_MASK[k*CW +: CW])
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .upCtrl  (upCtrl[k*CW +: CW]),
      .upValid (upValid[k]),
      .upStall (upStall[k]),
      .stall   (bus.stall[k]),
      .flush   (bus.flush[k]),
      .ctrlQ   (ctrlQ[k*CW +: CW]),
      .validQ  (validQ[k])
    );
  end

  // A stalled stage with a moving, live predecessor would be overwritten.
  always_comb begin
    errSet = 1'b0;
    for (int k = 0; k < NSTAGE - 1; k++) begin
      errSet = errSet | (bus.stall[k+1] & ~bus.stall[k] & ~bus.flush[k] &
                         validQ[k] & ~bus.flush[k+1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallErr <= 1'b0;
    end else if (errSet) begin
      stallErr <= 1'b1;
    end
  end

  always_comb begin
    occCnt = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      occCnt = occCnt + OCW'(validQ[k]);
    end
  end

  assign bus.ctrl_q    = ctrlQ;
  assign bus.valid_q   = validQ;
  assign bus.occ_cnt   = occCnt;
  assign bus.stall_err = stallErr;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain: a 4x16 build with a narrowed stage-2 mask
// and a 6x24 build with full masks, checked against hand-computed vectors.
module tb_ctrl_pipe_chain;

  logic clk;
  logic rst;
  int   nChk;
  int   nErr;

  ctrl_pipe_if #(.NSTAGE(4), .CW(16)) bus ();
  ctrl_pipe_if #(.NSTAGE(6), .CW(24)) bus6 ();

  ctrl_pipe_chain #(
    .NSTAGE    (4),
    .CW        (16),
    .KEEP_MASK ({16'hFFFF, 16'h00FF, 16'hFFFF, 16'hFFFF})
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ctrl_pipe_chain #(
    .NSTAGE (6),
    .CW     (24)
  ) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ctrl;
    logic        vd;
    logic        sd;
    logic [3:0]  st;
    logic [3:0]  fl;
    logic [3:0]  eV;
    logic [15:0] e0, e1, e2, e3;
    logic [2:0]  eOcc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] ctrl, input logic vd, input logic sd,
                     input logic [3:0] st, input logic [3:0] fl, input logic [3:0] eV,
                     input logic [15:0] e0, input logic [15:0] e1,
                     input logic [15:0] e2, input logic [15:0] e3,
                     input logic [2:0] eOcc);
    vec_t v;
    v.ctrl = ctrl; v.vd = vd; v.sd = sd; v.st = st; v.fl = fl; v.eV = eV;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.eOcc = eOcc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nChk = 0;
    nErr = 0;
    rst = 1'b0;
    bus.ctrl_d = '0; bus.valid_d = 1'b0; bus.stall_d = 1'b0; bus.stall = '0; bus.flush = '0;
    bus6.ctrl_d = '0; bus6.valid_d = 1'b0; bus6.stall_d = 1'b0; bus6.stall = '0; bus6.flush = '0;

    //   ctrl      vd  sd  stall    flush    validQ   s0        s1        s2        s3        occ
    // streaming A5/A6/A7 and drain
    add(16'h00A5, 1, 0, 4'b0000, 4'b0000, 4'b0001, 16'h00A5, 16'h0000, 16'h0000, 16'h0000, 3'd1);
    add(16'h00A6, 1, 0, 4'b0000, 4'b0000, 4'b0011, 16'h00A6, 16'h00A5, 16'h0000, 16'h0000, 3'd2);
    add(16'h00A7, 1, 0, 4'b0000, 4'b0000, 4'b0111, 16'h00A7, 16'h00A6, 16'h00A5, 16'h0000, 3'd3);
    add(16'h0000, 0, 0, 4'b0000, 4'b0000, 4'b1110, 16'h0000, 16'h00A7, 16'h00A6, 16'h00A5, 3'd3);
    add(16'h0000, 0, 0, 4'b0000, 4'b0000, 4'b1100, 16'h0000, 16'h0000, 16'h00A7, 16'h00A6, 3'd2);
    add(16'h0000, 0, 0, 4'b0000, 4'b0000, 4'b1000, 16'h0000, 16'h0000, 16'h0000, 16'h00A7, 3'd1);
    add(16'h0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0);
    // stage-2 mask 00FF
    add(16'hFFFF, 1, 0, 4'b0000, 4'b0000, 4'b0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 3'd1);
    add(16'h1234, 1, 0, 4'b0000, 4'b0000, 4'b0011, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000, 3'd2);
    add(16'h5678, 1, 0, 4'b0000, 4'b0000, 4'b0111, 16'h5678, 16'h1234, 16'h00FF, 16'h0000, 3'd3);
    add(16'h9ABC, 1, 0, 4'b0000, 4'b0000, 4'b1111, 16'h9ABC, 16'h5678, 16'h0034, 16'h00FF, 3'd4);
    // stage 0 stalled two cycles: bubbles into stage 1
    add(16'hDEAD, 1, 0, 4'b0001, 4'b0000, 4'b1101, 16'h9ABC, 16'h0000, 16'h0078, 16'h0034, 3'd3);
    add(16'hDEAD, 1, 0, 4'b0001, 4'b0000, 4'b1001, 16'h9ABC, 16'h0000, 16'h0000, 16'h0078, 3'd2);
    add(16'hDEAD, 1, 0, 4'b0000, 4'b0000, 4'b0011, 16'hDEAD, 16'h9ABC, 16'h0000, 16'h0000, 3'd2);
    // decode stalled: bubble into stage 0
    add(16'hBEEF, 1, 1, 4'b0000, 4'b0000, 4'b0110, 16'h0000, 16'hDEAD, 16'h00BC, 16'h0000, 3'd2);
    // flush beats stall on stage 1
    add(16'h0000, 0, 0, 4'b0010, 4'b0010, 4'b1000, 16'h0000, 16'h0000, 16'h0000, 16'h00BC, 3'd1);
    // last stage stalled holds its word
    add(16'h0111, 1, 0, 4'b1000, 4'b0000, 4'b1001, 16'h0111, 16'h0000, 16'h0000, 16'h00BC, 3'd2);
    add(16'h0000, 0, 0, 4'b1000, 4'b0000, 4'b1010, 16'h0000, 16'h0111, 16'h0000, 16'h00BC, 3'd2);
    add(16'h0000, 0, 0, 4'b0000, 4'b0000, 4'b0100, 16'h0000, 16'h0000, 16'h0011, 16'h0000, 3'd1);
    // flush everything
    add(16'h4444, 1, 0, 4'b0000, 4'b1111, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0);

    #1;
    chk("reset ctrl_q", 64'(bus.ctrl_q), 64'd0);
    chk("reset valid_q", 64'(bus.valid_q), 64'd0);
    chk("reset occ_cnt", 64'(bus.occ_cnt), 64'd0);
    chk("reset stall_err", 64'(bus.stall_err), 64'd0);
    chk("reset6 valid_q", 64'(bus6.valid_q), 64'd0);
    step();
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.ctrl_d  = vecs[i].ctrl;
      bus.valid_d = vecs[i].vd;
      bus.stall_d = vecs[i].sd;
      bus.stall   = vecs[i].st;
      bus.flush   = vecs[i].fl;
      step();
      chk($sformatf("v%0d valid_q", i), 64'(bus.valid_q), 64'(vecs[i].eV));
      chk($sformatf("v%0d ctrl0", i), 64'(bus.ctrl_q[0 +: 16]), 64'(vecs[i].e0));
      chk($sformatf("v%0d ctrl1", i), 64'(bus.ctrl_q[16 +: 16]), 64'(vecs[i].e1));
      chk($sformatf("v%0d ctrl2", i), 64'(bus.ctrl_q[32 +: 16]), 64'(vecs[i].e2));
      chk($sformatf("v%0d ctrl3", i), 64'(bus.ctrl_q[48 +: 16]), 64'(vecs[i].e3));
      chk($sformatf("v%0d occ_cnt", i), 64'(bus.occ_cnt), 64'(vecs[i].eOcc));
      chk($sformatf("v%0d stall_err", i), 64'(bus.stall_err), 64'd0);
    end

    // Illegal stall: stage 1 stalls while stage 0 holds live data.
    bus.ctrl_d = 16'h0AAA; bus.valid_d = 1'b1; bus.stall_d = 1'b0; bus.stall = '0; bus.flush = '0;
    step();
    chk("ill pre valid_q", 64'(bus.valid_q), 64'h1);
    chk("ill pre stall_err", 64'(bus.stall_err), 64'd0);
    bus.valid_d = 1'b0; bus.ctrl_d = '0; bus.stall = 4'b0010;
    step();
    chk("ill stall_err set", 64'(bus.stall_err), 64'd1);
    chk("ill valid_q", 64'(bus.valid_q), 64'd0);
    bus.stall = '0;
    step();
    step();
    chk("ill stall_err sticky", 64'(bus.stall_err), 64'd1);

    // Reset in the middle of a stream clears everything without a clock edge.
    bus.ctrl_d = 16'h0BBB; bus.valid_d = 1'b1;
    step();
    step();
    chk("mid valid_q", 64'(bus.valid_q), 64'h3);
    chk("mid ctrl1", 64'(bus.ctrl_q[16 +: 16]), 64'h0BBB);
    #2 rst = 1'b0;
    #1;
    chk("arst ctrl_q", 64'(bus.ctrl_q), 64'd0);
    chk("arst valid_q", 64'(bus.valid_q), 64'd0);
    chk("arst occ_cnt", 64'(bus.occ_cnt), 64'd0);
    chk("arst stall_err", 64'(bus.stall_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.ctrl_d = '0; bus.valid_d = 1'b0;

    // Six-stage, 24-bit build: six consecutive words.
    bus6.valid_d = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus6.ctrl_d = 24'hA50000 | 24'(i);
      step();
      if (i == 4) begin
        chk("n6 cyc5 valid5", 64'(bus6.valid_q[5]), 64'd0);
        chk("n6 cyc5 occ", 64'(bus6.occ_cnt), 64'd5);
      end
    end
    chk("n6 cyc6 ctrl5", 64'(bus6.ctrl_q[120 +: 24]), 64'hA50000);
    chk("n6 cyc6 ctrl0", 64'(bus6.ctrl_q[0 +: 24]), 64'hA50005);
    chk("n6 cyc6 occ", 64'(bus6.occ_cnt), 64'd6);
    bus6.valid_d = 1'b0; bus6.ctrl_d = '0;
    step();
    chk("n6 cyc7 ctrl5", 64'(bus6.ctrl_q[120 +: 24]), 64'hA50001);
    chk("n6 cyc7 occ", 64'(bus6.occ_cnt), 64'd5);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
